// File: rtl/rv_imm_pkg.sv
// Shared definitions for the immediate-decode stage: RISC-V major opcodes,
// the format tag encoding and the datapath-width legality check.
package rv_imm_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    // Only RV32 and RV64 datapaths are supported.
    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/rv_imm_decode.sv
// Purely combinational immediate decoder: raw instruction in, extended
// immediate plus format tag and illegal-opcode flag out.
module rv_imm_decode
    import rv_imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    localparam bit IS64 = (XLEN == 64);

    // The raw immediate fields are held as signed values so that a width
    // cast to XLEN performs the sign extension.
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode classification; unknown opcodes give NONE/0 and raise illegal.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR: begin
                imm = XLEN'(imm_i);
                fmt = FMT_I;
            end
            OP_IMM32: begin
                if (IS64) begin
                    imm = XLEN'(imm_i);
                    fmt = FMT_I;
                end else begin
                    illegal = 1'b1;
                end
            end
            STORE: begin
                imm = XLEN'(imm_s);
                fmt = FMT_S;
            end
            BRANCH: begin
                imm = XLEN'(imm_b);
                fmt = FMT_B;
            end
            LUI, AUIPC: begin
                imm = XLEN'(imm_u);
                fmt = FMT_U;
            end
            JAL: begin
                imm = XLEN'(imm_j);
                fmt = FMT_J;
            end
            SYSTEM: begin
                if ((instr[14:12] != 3'b000) && EN_ZIMM) begin
                    imm = XLEN'(instr[19:15]);
                    fmt = FMT_Z;
                end else begin
                    imm = XLEN'(imm_i);
                    fmt = FMT_I;
                end
            end
            OP: begin
                fmt = FMT_NONE;
            end
            OP32: begin
                if (!IS64) begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_imm_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer so that
// downstream back-pressure never reaches fetch through a combinational path.
module rv_imm_stage
    import rv_imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("rv_imm_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    rv_imm_decode #(
        .XLEN    (XLEN),
        .EN_ZIMM (EN_ZIMM)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    logic            main_valid_q, main_valid_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d;
    fmt_e            main_fmt_q, main_fmt_d;
    logic            main_illegal_q, main_illegal_d;
    logic [31:0]     main_instr_q, main_instr_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d;

    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    fmt_e            skid_fmt_q, skid_fmt_d;
    logic            skid_illegal_q, skid_illegal_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic accept;
    logic xfer;

    // Ready depends only on flop state (and reset), never on out_ready.
    assign in_ready = !skid_valid_q && !rst;
    assign accept   = in_valid && in_ready && !flush;
    assign xfer     = main_valid_q && out_ready;

    // Next-state of both entries: flush empties, a full skid refills main on
    // transfer, otherwise an accepted word goes to main if it is free or
    // draining this cycle, and to skid only when main is stalled.
    always_comb begin
        main_valid_d   = main_valid_q;
        main_imm_d     = main_imm_q;
        main_fmt_d     = main_fmt_q;
        main_illegal_d = main_illegal_q;
        main_instr_d   = main_instr_q;
        main_pc_d      = main_pc_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_fmt_d     = skid_fmt_q;
        skid_illegal_d = skid_illegal_q;
        skid_instr_d   = skid_instr_q;
        skid_pc_d      = skid_pc_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (xfer) begin
                main_imm_d     = skid_imm_q;
                main_fmt_d     = skid_fmt_q;
                main_illegal_d = skid_illegal_q;
                main_instr_d   = skid_instr_q;
                main_pc_d      = skid_pc_q;
                skid_valid_d   = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || xfer) begin
                main_valid_d   = 1'b1;
                main_imm_d     = dec_imm;
                main_fmt_d     = dec_fmt;
                main_illegal_d = dec_illegal;
                main_instr_d   = in_instr;
                main_pc_d      = in_pc;
            end else begin
                skid_valid_d   = 1'b1;
                skid_imm_d     = dec_imm;
                skid_fmt_d     = dec_fmt;
                skid_illegal_d = dec_illegal;
                skid_instr_d   = in_instr;
                skid_pc_d      = in_pc;
            end
        end else if (xfer) begin
            main_valid_d = 1'b0;
        end
    end

    // Entry registers; reset clears every field of both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q   <= 1'b0;
            main_imm_q     <= '0;
            main_fmt_q     <= FMT_NONE;
            main_illegal_q <= 1'b0;
            main_instr_q   <= '0;
            main_pc_q      <= '0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= FMT_NONE;
            skid_illegal_q <= 1'b0;
            skid_instr_q   <= '0;
            skid_pc_q      <= '0;
        end else begin
            main_valid_q   <= main_valid_d;
            main_imm_q     <= main_imm_d;
            main_fmt_q     <= main_fmt_d;
            main_illegal_q <= main_illegal_d;
            main_instr_q   <= main_instr_d;
            main_pc_q      <= main_pc_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_fmt_q     <= skid_fmt_d;
            skid_illegal_q <= skid_illegal_d;
            skid_instr_q   <= skid_instr_d;
            skid_pc_q      <= skid_pc_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_imm_q;
    assign out_fmt     = main_fmt_q;
    assign out_illegal = main_illegal_q;
    assign out_instr   = main_instr_q;
    assign out_pc      = main_pc_q;

endmodule

// File: tb/tb_rv_imm_stage.sv
// Bench for rv_imm_stage: an RV32/zimm instance and an RV64/no-zimm instance
// are driven in lockstep and compared against a queue-based reference model
// plus a table of hand-decoded instructions.
module tb_rv_imm_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready_a, out_valid_a, out_illegal_a;
    logic [31:0] out_imm_a, out_instr_a, out_pc_a;
    logic [2:0]  out_fmt_a;

    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [63:0] out_imm_b, out_pc_b;
    logic [31:0] out_instr_b;
    logic [2:0]  out_fmt_b;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    entry_t model_q[$];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    vec_t       tbl[14];
    logic [6:0] ops[14];

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    rv_imm_stage #(.XLEN(32), .EN_ZIMM(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a),
        .out_instr(out_instr_a), .out_pc(out_pc_a)
    );

    rv_imm_stage #(.XLEN(64), .EN_ZIMM(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b),
        .out_instr(out_instr_b), .out_pc(out_pc_b)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference decoder: field values computed as integers, sign applied by
    // subtracting 2^width when the top instruction bit is set.
    task automatic refDecode(input logic [31:0] ins, input int xlen, input bit ez,
                             output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
        longint v;
        v   = 0;
        fmt = 3'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: fmt = 3'd1;
            7'h1B: if (xlen == 64) fmt = 3'd1; else ill = 1'b1;
            7'h23: fmt = 3'd2;
            7'h63: fmt = 3'd3;
            7'h37, 7'h17: fmt = 3'd4;
            7'h6F: fmt = 3'd5;
            7'h73: fmt = ((ins[14:12] != 3'd0) && ez) ? 3'd6 : 3'd1;
            7'h33: fmt = 3'd0;
            7'h3B: if (xlen != 64) ill = 1'b1;
            default: ill = 1'b1;
        endcase
        case (fmt)
            3'd1: begin v = longint'(ins[31:20]); if (ins[31]) v -= 4096; end
            3'd2: begin v = longint'({ins[31:25], ins[11:7]}); if (ins[31]) v -= 4096; end
            3'd3: begin
                v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
                if (ins[31]) v -= 8192;
            end
            3'd4: begin
                v = longint'(ins[31:20 - 8]) * 4096;
                if (ins[31]) v -= 64'h1_0000_0000;
            end
            3'd5: begin
                v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
                if (ins[31]) v -= 2097152;
            end
            3'd6: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
    endtask

    // Compare both DUTs against the model's occupancy and head entry.
    task automatic checkOutput();
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        bit          exp_rdy;
        entry_t      h;
        exp_rdy = (model_q.size() < 2) && !rst;
        cmp("in_ready_32", 64'(in_ready_a), 64'(exp_rdy));
        cmp("in_ready_64", 64'(in_ready_b), 64'(exp_rdy));
        cmp("out_valid_32", 64'(out_valid_a), 64'(model_q.size() > 0));
        cmp("out_valid_64", 64'(out_valid_b), 64'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            h = model_q[0];
            refDecode(h.instr, 32, 1'b1, imm, fmt, ill);
            cmp("imm_32", 64'(out_imm_a), imm);
            cmp("fmt_32", 64'(out_fmt_a), 64'(fmt));
            cmp("illegal_32", 64'(out_illegal_a), 64'(ill));
            cmp("instr_32", 64'(out_instr_a), 64'(h.instr));
            cmp("pc_32", 64'(out_pc_a), 64'(h.pc[31:0]));
            refDecode(h.instr, 64, 1'b0, imm, fmt, ill);
            cmp("imm_64", out_imm_b, imm);
            cmp("fmt_64", 64'(out_fmt_b), 64'(fmt));
            cmp("illegal_64", 64'(out_illegal_b), 64'(ill));
            cmp("instr_64", 64'(out_instr_b), 64'(h.instr));
            cmp("pc_64", out_pc_b, h.pc);
        end
    endtask

    // One clock cycle: check at the falling edge, drive, then advance the model.
    task automatic applyStimulus(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                                 input bit ordy, input bit fl, input bit r, output bit acc);
        bit xf;
        @(negedge clk);
        if (check_en) checkOutput();
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        acc = v && (model_q.size() < 2) && !r && !fl;
        xf  = (model_q.size() > 0) && ordy;
        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
        end else begin
            if (xf) void'(model_q.pop_front());
            if (acc) model_q.push_back('{ins, pc});
        end
    endtask

    task automatic checkResetZero(input bit exp_rdy);
        cmp("rst_in_ready_32", 64'(in_ready_a), 64'(exp_rdy));
        cmp("rst_out_valid_32", 64'(out_valid_a), 64'd0);
        cmp("rst_imm_32", 64'(out_imm_a), 64'd0);
        cmp("rst_fmt_32", 64'(out_fmt_a), 64'd0);
        cmp("rst_illegal_32", 64'(out_illegal_a), 64'd0);
        cmp("rst_instr_32", 64'(out_instr_a), 64'd0);
        cmp("rst_pc_32", 64'(out_pc_a), 64'd0);
        cmp("rst_out_valid_64", 64'(out_valid_b), 64'd0);
        cmp("rst_imm_64", out_imm_b, 64'd0);
        cmp("rst_pc_64", out_pc_b, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        bit          acc, last_v, last_acc, last_fl, v, fl, r, ordy;
        logic [31:0] ins, rnd;
        logic [63:0] pc;

        tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        tbl[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
        tbl[2]  = '{32'h0000006F, 32'h00000000, 3'd5, 1'b0, 64'h0000000000000000, 3'd5, 1'b0};
        tbl[3]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
        tbl[4]  = '{32'h300FD073, 32'h0000001F, 3'd6, 1'b0, 64'h0000000000000300, 3'd1, 1'b0};
        tbl[5]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
        tbl[6]  = '{32'h0010009B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd1, 1'b0};
        tbl[7]  = '{32'h0000003B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b0};
        tbl[8]  = '{32'h00000033, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
        tbl[9]  = '{32'hFE112C23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};
        tbl[10] = '{32'h7FF00083, 32'h000007FF, 3'd1, 1'b0, 64'h00000000000007FF, 3'd1, 1'b0};
        tbl[11] = '{32'h00000073, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0};
        tbl[12] = '{32'h8000006F, 32'hFFF00000, 3'd5, 1'b0, 64'hFFFFFFFFFFF00000, 3'd5, 1'b0};
        tbl[13] = '{32'h00001017, 32'h00001000, 3'd4, 1'b0, 64'h0000000000001000, 3'd4, 1'b0};
        ops = '{7'h13, 7'h1B, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                7'h37, 7'h17, 7'h73, 7'h33, 7'h3B, 7'h7F, 7'h0B};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;

        // Reset and post-reset state.
        applyStimulus(0, 0, 0, 0, 0, 1, acc);
        applyStimulus(0, 0, 0, 0, 0, 1, acc);
        #1 checkResetZero(1'b0);
        check_en = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 0, 1, 0, 0, acc);

        // Table vectors streamed back to back; each result is visible right after its accept edge.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, tbl[i].instr, 64'h8000_0000_0000_1000 + 64'(i * 4), 1, 0, 0, acc);
            #1;
            cmp("tbl_valid_32", 64'(out_valid_a), 64'd1);
            cmp("tbl_imm_32", 64'(out_imm_a), 64'(tbl[i].imm32));
            cmp("tbl_fmt_32", 64'(out_fmt_a), 64'(tbl[i].fmt32));
            cmp("tbl_ill_32", 64'(out_illegal_a), 64'(tbl[i].ill32));
            cmp("tbl_imm_64", out_imm_b, tbl[i].imm64);
            cmp("tbl_fmt_64", 64'(out_fmt_b), 64'(tbl[i].fmt64));
            cmp("tbl_ill_64", 64'(out_illegal_b), 64'(tbl[i].ill64));
        end
        applyStimulus(0, 0, 0, 1, 0, 0, acc);

        // Back-pressure: A, B fill both entries, C stalls, then all drain in order.
        applyStimulus(1, 32'h00100093, 64'hA0, 0, 0, 0, acc);
        applyStimulus(1, 32'h00200113, 64'hA4, 0, 0, 0, acc);
        #1 cmp("in_ready_after_B", 64'(in_ready_a), 64'd0);
        applyStimulus(1, 32'h00300193, 64'hA8, 0, 0, 0, acc);
        applyStimulus(1, 32'h00300193, 64'hA8, 0, 0, 0, acc);
        applyStimulus(1, 32'h00300193, 64'hA8, 1, 0, 0, acc);
        #1 cmp("drain_second_B", 64'(out_instr_a), 64'h00200113);
        applyStimulus(1, 32'h00300193, 64'hA8, 1, 0, 0, acc);
        #1 cmp("drain_third_C", 64'(out_instr_a), 64'h00300193);
        applyStimulus(0, 0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 0, 1, 0, 0, acc);

        // Flush with both entries full and a new input offered in the same cycle.
        applyStimulus(1, 32'h00400213, 64'hB0, 0, 0, 0, acc);
        applyStimulus(1, 32'h00500293, 64'hB4, 0, 0, 0, acc);
        applyStimulus(1, 32'h00600313, 64'hB8, 0, 1, 0, acc);
        #1;
        cmp("flush_out_valid", 64'(out_valid_a), 64'd0);
        cmp("flush_in_ready", 64'(in_ready_a), 64'd1);
        applyStimulus(0, 0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 0, 1, 0, 0, acc);

        // Reset in the middle of a stalled stream.
        applyStimulus(1, 32'h00700393, 64'hC0, 0, 0, 0, acc);
        applyStimulus(1, 32'h00800413, 64'hC4, 0, 0, 0, acc);
        applyStimulus(1, 32'h00900493, 64'hC8, 0, 0, 1, acc);
        #1 checkResetZero(1'b0);
        applyStimulus(0, 0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 0, 1, 0, 0, acc);

        // Randomised traffic with occasional flush and reset; stalled inputs are held.
        last_v = 1'b0; last_acc = 1'b0; last_fl = 1'b0;
        ins = '0; pc = '0;
        for (int c = 0; c < 600; c++) begin
            fl   = ($urandom_range(0, 24) == 0);
            r    = ($urandom_range(0, 149) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            if (last_v && !last_acc && !last_fl) begin
                v = 1'b1;
            end else begin
                v   = ($urandom_range(0, 3) != 0);
                rnd = $urandom();
                ins = {rnd[31:7], ops[$urandom_range(0, 13)]};
                pc  = {$urandom(), $urandom()};
            end
            applyStimulus(v, ins, pc, ordy, fl, r, acc);
            last_v   = v;
            last_acc = acc;
            last_fl  = fl || r;
        end
        applyStimulus(0, 0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 0, 1, 0, 0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_imm_stage.md
Name: rv_imm_stage

Overview:
Registered immediate-decode stage between the IF/ID boundary and the ID/EX register of the five-stage pipeline. It accepts one raw instruction per cycle on a valid/ready handshake and decodes the immediate, sign- or zero-extended to XLEN, plus a format tag and an illegal flag. Results sit in a 2-entry skid buffer so back-pressure from ID/EX never creates a combinational ready path to fetch. Supports RV32I and RV64I extension rules and CSR zimm.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64.
EN_ZIMM, 1, when 1, SYSTEM instructions with funct3!=0 produce the zero-extended zimm; when 0 they produce I-type.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  discard all buffered and in-flight entries
in_valid  in  1  in_instr/in_pc valid
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction PC (passed through)
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_imm  out  XLEN  decoded immediate
out_fmt  out  3  0=NONE 1=I 2=S 3=B 4=U 5=J 6=Z
out_illegal  out  1  opcode not recognised
out_instr  out  32  instruction passed through
out_pc  out  XLEN  PC passed through

Behaviour:
- Decode (combinational on in_instr, registered on accept), opcode = instr[6:0]:
  - I: OP-IMM 0010011, LOAD 0000011, JALR 1100111, and OP-IMM-32 0011011 only when XLEN=64. imm = sext(instr[31:20]).
  - S: 0100011, imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: LUI 0110111 and AUIPC 0010111, imm = sext({instr[31:12], 12'b0}). The upper bits copy instr[31] when XLEN=64.
  - J: 1101111, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - SYSTEM 1110011: if funct3!=0 and EN_ZIMM=1, Z with imm = zext(instr[19:15]); otherwise I.
  - OP 0110011, and OP-32 0111011 when XLEN=64: fmt NONE, imm 0, illegal 0.
  - Any other opcode, including OP-IMM-32/OP-32 when XLEN=32: fmt NONE, imm 0, illegal 1. There is no I-type fallback.
- Buffer: two entries, main (drives out_*) and skid, each with its own valid bit.
  - in_ready = !skid_valid, registered; it is 0 while rst=1.
  - Accept happens when in_valid && in_ready && !flush.
  - Latency is 1 cycle from accept to out_valid. Sustained throughput is 1 per cycle.
- Transfer happens when out_valid && out_ready.
  - On accept with main empty, or main transferring with skid empty: load main.
  - On accept with main full and not transferring: load skid.
  - On transfer with skid full: move skid to main. Simultaneous accept is impossible because in_ready=0.
  - Order is strictly FIFO; there is no loss or duplication.
- Output stability: while out_valid && !out_ready, all out_* hold their values. The upstream must hold inputs while in_valid && !in_ready.
- flush (synchronous, takes priority over everything except rst):
  - Next cycle, main_valid=0 and skid_valid=0, in_ready=1.
  - Input presented in the flush cycle is dropped.
  - A transfer in the flush cycle still counts as completed.
- Reset:
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_instr=0, out_pc=0.
  - Skid contents are cleared; in_ready=1 in the first cycle after rst falls.
  - Reset mid-stream discards everything.
- Data registers load only on accept or move, never on transfer alone.

Decomposition:
- Package rv_imm_pkg holds:
  - opcode localparams (OP_IMM, OP_IMM32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, OP, OP32);
  - fmt codes FMT_NONE..FMT_Z;
  - the XLEN legality check.
- Sub-module rv_imm_decode: purely combinational, parametrised by XLEN and EN_ZIMM. It maps instr to {imm, fmt, illegal}.
- rv_imm_stage instantiates rv_imm_decode once on the input side and contains the skid buffer and control.

Test Plan:
1. XLEN=32, in 0xFFF00093 (addi x1,x0,-1) with out_ready=1 → one cycle later out_valid=1, imm 0xFFFFFFFF, fmt 1, illegal 0.
2. In 0xFE000EE3 (beq offset -4) → imm 0xFFFFFFFC, fmt 3. Then 0x0000006F (jal 0) → imm 0, fmt 5, back to back with no bubble.
3. In 0x800000B7 (lui 0x80000): XLEN=32 → imm 0x80000000; XLEN=64 → imm 0xFFFFFFFF80000000, fmt 4.
4. In 0x300FD073 (csrrwi, zimm 31) → imm 0x0000001F, fmt 6. With EN_ZIMM=0 → imm 0x00000300, fmt 1. In 0x0000007F → illegal 1, imm 0, fmt 0.
5. Hold out_ready=0 and send A, B, C → in_ready falls after B and C stalls. Raise out_ready → A, B, C emerge in order on consecutive cycles; out_* stable while stalled.
6. Both entries full, assert flush for 1 cycle with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears. Assert rst mid-stream → same empty state, with all outputs zero.
